// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, special exponent code and the unpacked-operand type
// used by the alignment/add front end.
package fp32_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    // man carries the hidden bit at [MAN_W]; zero for flushed operands.
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_unp_t;
endpackage

// File: rtl/fp32_unpack.sv
// Combinational unpack of one FP32 operand into {effective sign, exp, mantissa}.
// Zero-exponent operands are flushed: mantissa 0 and sign forced positive.
module fp32_unpack
    import fp32_pkg::*;
#(
    parameter int FLUSH_DENORM = 1
) (
    input  logic [31:0] val,
    input  logic        neg,
    output fp_unp_t     op
);
    logic [EXP_W-1:0] exp_f;

    assign exp_f = val[30:23];

    always_comb begin
        op     = '0;
        op.exp = exp_f;
        if ((exp_f == '0) && (FLUSH_DENORM != 0)) begin
            op.sign = 1'b0;
            op.man  = '0;
        end else begin
            op.sign = val[31] ^ neg;
            op.man  = {exp_f != '0, val[MAN_W-1:0]};
        end
    end
endmodule

// File: rtl/fp32_align_add.sv
// Two-stage elastic FP32 align-and-add front end: stage 1 orders the operands
// and flags specials, stage 2 aligns the smaller mantissa and adds/subtracts.
module fp32_align_add
    import fp32_pkg::*;
#(
    parameter int FLUSH_DENORM = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [24:0] res,
    output logic [7:0]  exp_base,
    output logic        sign_res,
    output logic        special,
    output logic        nan
);
    fp_unp_t ua, ub, big_c, small_c;

    fp32_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_unpack_a (.val(a), .neg(1'b0),   .op(ua));
    fp32_unpack #(.FLUSH_DENORM(FLUSH_DENORM)) u_unpack_b (.val(b), .neg(op_sub), .op(ub));

    logic             a_big, a_nan, b_nan, a_inf, b_inf;
    logic             special_c, nan_c, inf_sign_c;
    logic [EXP_W-1:0] diff_c;

    // Tie on {exp, man} keeps a as the big operand.
    assign a_big   = {ua.exp, ua.man} >= {ub.exp, ub.man};
    assign big_c   = a_big ? ua : ub;
    assign small_c = a_big ? ub : ua;
    assign diff_c  = big_c.exp - small_c.exp;

    assign a_nan      = (ua.exp == EXP_SPECIAL) && (ua.man[MAN_W-1:0] != '0);
    assign b_nan      = (ub.exp == EXP_SPECIAL) && (ub.man[MAN_W-1:0] != '0);
    assign a_inf      = (ua.exp == EXP_SPECIAL) && (ua.man[MAN_W-1:0] == '0);
    assign b_inf      = (ub.exp == EXP_SPECIAL) && (ub.man[MAN_W-1:0] == '0);
    assign special_c  = (ua.exp == EXP_SPECIAL) || (ub.exp == EXP_SPECIAL);
    assign nan_c      = a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign));
    assign inf_sign_c = a_inf ? ua.sign : ub.sign;

    logic             s1_valid, s2_valid, s2_ready, s1_load;
    fp_unp_t          s1_big;
    logic [MAN_W:0]   s1_small_man;
    logic [EXP_W-1:0] s1_diff;
    logic             s1_sub, s1_special, s1_nan, s1_inf_sign;

    assign s2_ready  = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_ready;
    assign in_ready  = !rst && s1_load;
    assign out_valid = !rst && s2_valid;

    logic [MAN_W:0]   aligned_c;
    logic [MAN_W+1:0] sum_c;

    // Truncating alignment: bits shifted out are simply dropped.
    assign aligned_c = (s1_diff >= EXP_W'(MAN_W + 1)) ? '0 : (s1_small_man >> s1_diff);
    assign sum_c     = s1_sub ? ({1'b0, s1_big.man} - {1'b0, aligned_c})
                              : ({1'b0, s1_big.man} + {1'b0, aligned_c});

    always_ff @(posedge clk) begin
        if (s1_load) begin
            s1_big       <= big_c;
            s1_small_man <= small_c.man;
            s1_diff      <= diff_c;
            s1_sub       <= big_c.sign ^ small_c.sign;
            s1_special   <= special_c;
            s1_nan       <= nan_c;
            s1_inf_sign  <= inf_sign_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            res      <= '0;
            exp_base <= '0;
            sign_res <= 1'b0;
            special  <= 1'b0;
            nan      <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    special <= s1_special;
                    nan     <= s1_special && s1_nan;
                    if (s1_special) begin
                        res      <= '0;
                        exp_base <= EXP_SPECIAL;
                        sign_res <= !s1_nan && s1_inf_sign;
                    end else begin
                        res      <= sum_c;
                        exp_base <= s1_big.exp;
                        sign_res <= (sum_c != '0) && s1_big.sign;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fp32_align_add.sv
// Scoreboard bench for fp32_align_add: directed corner pairs, a stall/in-flight
// scenario, reset flush, then randomized pairs against an arithmetic model.
module tb_fp32_align_add;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [24:0] res;
    logic [7:0]  exp_base;
    logic        sign_res, special, nan;

    fp32_align_add #(.FLUSH_DENORM(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .exp_base(exp_base), .sign_res(sign_res), .special(special), .nan(nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] res;
        logic [7:0]  eb;
        logic        s;
        logic        sp;
        logic        n;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   lat_mode = 0;
    bit   rand_ready = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [24:0] r, input logic [7:0] eb, input logic s,
                                input logic sp, input logic n);
        exp_t e;
        e.res = r; e.eb = eb; e.s = s; e.sp = sp; e.n = n; e.cyc = 0; e.lat = 0;
        return e;
    endfunction

    // Reference model: plain integer arithmetic on the decoded fields.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        int ea, eb, fa, fb, sa, sb, ma, mb;
        int e_big, e_sml, m_big, m_sml, s_big, s_sml, d, sm, r;
        longint ka, kb;
        bit na, nb, ia, ib, nn;
        ea = int'(x[30:23]); eb = int'(y[30:23]);
        fa = int'(x[22:0]);  fb = int'(y[22:0]);
        sa = int'(x[31]);    sb = int'(y[31] ^ sub);
        if (ea == 255 || eb == 255) begin
            na = (ea == 255) && (fa != 0);
            nb = (eb == 255) && (fb != 0);
            ia = (ea == 255) && (fa == 0);
            ib = (eb == 255) && (fb == 0);
            nn = na || nb || (ia && ib && (sa != sb));
            return mk(25'd0, 8'd255, nn ? 1'b0 : (ia ? 1'(sa) : 1'(sb)), 1'b1, nn);
        end
        ma = (ea != 0) ? fa + (1 << 23) : 0;
        mb = (eb != 0) ? fb + (1 << 23) : 0;
        if (ea == 0) sa = 0;
        if (eb == 0) sb = 0;
        ka = longint'(ea) * 64'd16777216 + longint'(ma);
        kb = longint'(eb) * 64'd16777216 + longint'(mb);
        if (ka >= kb) begin
            e_big = ea; m_big = ma; s_big = sa; e_sml = eb; m_sml = mb; s_sml = sb;
        end else begin
            e_big = eb; m_big = mb; s_big = sb; e_sml = ea; m_sml = ma; s_sml = sa;
        end
        d  = e_big - e_sml;
        sm = (d >= 24) ? 0 : m_sml / (1 << d);
        r  = (s_big == s_sml) ? m_big + sm : m_big - sm;
        return mk(25'(r), 8'(e_big), (r == 0) ? 1'b0 : 1'(s_big), 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] rnd_op(input int near);
        int sel, e;
        logic [22:0] f;
        sel = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if ($urandom_range(0, 5) == 0) f = '0;
        case (sel)
            0: e = 0;
            1: begin e = 255; f = '0; end
            2: e = 255;
            default: begin
                if (sel < 9) e = near + int'($urandom_range(0, 60)) - 30;
                else e = int'($urandom_range(1, 254));
                if (e < 1) e = 1;
                if (e > 254) e = 254;
            end
        endcase
        return {1'($urandom), 8'(e), f};
    endfunction

    // Monitor: the head of the queue must match whenever a result is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got res=%h exp_base=%h with empty queue", res, exp_base);
            end else begin
                e = q[0];
                chk("result", {28'd0, res, exp_base, sign_res, special, nan},
                    {28'd0, e.res, e.eb, e.s, e.sp, e.n});
                if (out_ready) begin
                    if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_e(input logic [31:0] x, input logic [31:0] y, input logic sub, input exp_t e);
        bit done;
        int tries;
        a = x; b = y; op_sub = sub; in_valid = 1'b1;
        done = 0;
        tries = 0;
        while (!done && tries < 60) begin
            @(negedge clk);
            if (in_ready) begin
                e.cyc = cyc;
                e.lat = lat_mode;
                q.push_back(e);
                done = 1;
            end else begin
                tries++;
            end
            step();
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
        else if (lat_mode) chk("stream_wait", 64'(tries), 64'd0);
    endtask

    task automatic send_m(input logic [31:0] x, input logic [31:0] y, input logic sub);
        send_e(x, y, sub, model(x, y, sub));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        int k;
        in_valid = 1'b0;
        rand_ready = 0;
        out_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_fields", {28'd0, res, exp_base, sign_res, special, nan}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        step();

        // Directed corners, streamed back to back with out_ready high.
        lat_mode = 1;
        send_e(32'h3F800000, 32'h3F800000, 1'b0, mk(25'h1000000, 8'h7F, 1'b0, 1'b0, 1'b0));
        send_e(32'h3FC00000, 32'hBF400000, 1'b0, mk(25'h0600000, 8'h7F, 1'b0, 1'b0, 1'b0));
        send_e(32'h3F800000, 32'h3F800000, 1'b1, mk(25'h0000000, 8'h7F, 1'b0, 1'b0, 1'b0));
        send_e(32'h3F800000, 32'h30800000, 1'b0, mk(25'h0800000, 8'h7F, 1'b0, 1'b0, 1'b0));
        send_e(32'h3F800000, 32'h33800000, 1'b0, mk(25'h0800000, 8'h7F, 1'b0, 1'b0, 1'b0));
        send_e(32'h3F800000, 32'h34000000, 1'b0, mk(25'h0800001, 8'h7F, 1'b0, 1'b0, 1'b0));
        send_e(32'h7F800000, 32'hFF800000, 1'b0, mk(25'h0, 8'hFF, 1'b0, 1'b1, 1'b1));
        send_e(32'h7FC00001, 32'h3F800000, 1'b0, mk(25'h0, 8'hFF, 1'b0, 1'b1, 1'b1));
        send_e(32'hFF800000, 32'h3F800000, 1'b0, mk(25'h0, 8'hFF, 1'b1, 1'b1, 1'b0));
        send_e(32'h00000000, 32'h80000000, 1'b0, mk(25'h0, 8'h00, 1'b0, 1'b0, 1'b0));
        send_e(32'hBF800000, 32'h3F800000, 1'b1, mk(25'h1000000, 8'h7F, 1'b1, 1'b0, 1'b0));
        send_e(32'h00400000, 32'hBF800000, 1'b0, mk(25'h0800000, 8'h7F, 1'b1, 1'b0, 1'b0));
        drain();

        // Stall mid-stream: two pairs held, in_ready must drop, outputs stay put.
        lat_mode = 0;
        send_m(32'h40490FDB, 32'h3F000000, 1'b0);
        send_m(32'hC0000000, 32'h3E800000, 1'b1);
        out_ready = 1'b0;
        a = 32'h41200000; b = 32'hC1200001; op_sub = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("in_ready_stall", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_m(32'h41200000, 32'hC1200001, 1'b0);
        send_m(32'h3A800000, 32'h3F7FFFFF, 1'b1);
        drain();

        // Reset with two pairs in flight: nothing stale may come out afterwards.
        send_m(32'h3F800000, 32'h40000000, 1'b0);
        send_m(32'h40400000, 32'h3F800000, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        step();
        @(negedge clk);
        chk("rst_fields", {28'd0, res, exp_base, sign_res, special, nan}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_flush", 64'(in_ready), 64'd1);
        step();
        idle(6);

        // Randomized pairs with random gaps and random backpressure.
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            ra = rnd_op(127);
            rb = rnd_op(int'(ra[30:23]));
            send_m(ra, rb, 1'($urandom));
        end
        drain();
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
